// File: rtl/pic16_pkg.sv
// Shared types and defaults for the PIC16 program-counter sequencer.
// Holds the instruction-class encoding, the pipeline states and the reset/interrupt vectors.
package pic16_pkg;

    localparam int          PC_WIDTH_DEF     = 13;
    localparam int          DEPTH_LOG2_DEF   = 3;
    localparam logic [12:0] RESET_VECTOR_DEF = 13'h000;
    localparam logic [12:0] INT_VECTOR_DEF   = 13'h004;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_GOTO   = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_PCL_WR = 3'd4,
        OP_SKIP   = 3'd5
    } op_kind_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_t;

endpackage

// File: rtl/stack_depth_monitor.sv
// Tracks hardware return-stack occupancy from the push/pop strobes and raises
// sticky overflow/underflow flags; the stack itself wraps, so depth saturates.
module stack_depth_monitor #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    output logic stack_ovf,
    output logic stack_unf
);

    localparam logic [DEPTH_LOG2:0] DEPTH_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] DEPTH_ZERO = '0;
    localparam logic [DEPTH_LOG2:0] DEPTH_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] depth_r;
    logic                ovf_r;
    logic                unf_r;

    // Depth counter with saturating ends and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r <= DEPTH_ZERO;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (depth_r == DEPTH_FULL) begin
                        ovf_r <= 1'b1;
                    end else begin
                        depth_r <= depth_r + DEPTH_ONE;
                    end
                end
                2'b01: begin
                    if (depth_r == DEPTH_ZERO) begin
                        unf_r <= 1'b1;
                    end else begin
                        depth_r <= depth_r - DEPTH_ONE;
                    end
                end
                default: begin
                    depth_r <= depth_r;
                end
            endcase
        end
    end

    assign stack_ovf = ovf_r;
    assign stack_unf = unf_r;

endmodule

// File: rtl/pc_sequencer.sv
// PIC16 program-counter sequencer: owns the PC, models the fetch/execute pipeline
// with one flush slot per taken branch, and drives the hardware return stack.
module pc_sequencer
    import pic16_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter int                  DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(INT_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [2:0]          op_kind,
    input  logic [10:0]         target,
    input  logic [4:0]          pclath,
    input  logic [7:0]          pcl_wdata,
    input  logic                irq,
    input  logic [PC_WIDTH-1:0] stack_top,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                stack_push,
    output logic                stack_pop,
    output logic [PC_WIDTH-1:0] stack_din,
    output logic                irq_ack,
    output logic                stack_ovf,
    output logic                stack_unf
);

    seq_state_t          state_r;
    seq_state_t          state_nxt_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] jump_addr_s;
    logic [PC_WIDTH-1:0] pcl_addr_s;
    logic                push_s;
    logic                pop_s;
    logic                ack_s;
    logic [PC_WIDTH-1:0] din_s;

    assign pc_inc_s    = pc_r + PC_WIDTH'(1);
    assign jump_addr_s = PC_WIDTH'({pclath[4:3], target});
    assign pcl_addr_s  = PC_WIDTH'({pclath, pcl_wdata});

    // Next-PC mux, next state and stack/interrupt strobes
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        ack_s       = 1'b0;
        din_s       = pc_r;
        if (ce) begin
            if (state_r == ST_FLUSH) begin
                pc_nxt_s    = pc_inc_s;
                state_nxt_s = ST_RUN;
            end else begin
                case (op_kind)
                    OP_GOTO: begin
                        pc_nxt_s    = jump_addr_s;
                        state_nxt_s = ST_FLUSH;
                    end
                    OP_CALL: begin
                        push_s      = 1'b1;
                        pc_nxt_s    = jump_addr_s;
                        state_nxt_s = ST_FLUSH;
                    end
                    OP_RET: begin
                        pop_s       = 1'b1;
                        pc_nxt_s    = stack_top;
                        state_nxt_s = ST_FLUSH;
                    end
                    OP_PCL_WR: begin
                        pc_nxt_s    = pcl_addr_s;
                        state_nxt_s = ST_FLUSH;
                    end
                    OP_SKIP: begin
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = ST_FLUSH;
                    end
                    default: begin
                        // SEQ and the unused encodings; only here may an interrupt enter
                        if (irq) begin
                            push_s      = 1'b1;
                            ack_s       = 1'b1;
                            din_s       = pc_inc_s;
                            pc_nxt_s    = INT_VECTOR;
                            state_nxt_s = ST_FLUSH;
                        end else begin
                            pc_nxt_s    = pc_inc_s;
                            state_nxt_s = ST_RUN;
                        end
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // PC and pipeline state register; reset refills the pipeline from the reset vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FLUSH;
            pc_r    <= RESET_VECTOR;
        end else if (ce) begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end else begin
            state_r <= state_r;
            pc_r    <= pc_r;
        end
    end

    stack_depth_monitor #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_depth (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    assign pc         = pc_r;
    assign flush      = (state_r == ST_FLUSH);
    assign stack_push = push_s;
    assign stack_pop  = pop_s;
    assign stack_din  = din_s;
    assign irq_ack    = ack_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected
// observation for each cycle and an independent monitor compares it with the DUT.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [2:0]  op_kind;
    logic [10:0] target;
    logic [4:0]  pclath;
    logic [7:0]  pcl_wdata;
    logic        irq;
    logic [12:0] stack_top;
    logic [12:0] pc;
    logic        flush;
    logic        stack_push;
    logic        stack_pop;
    logic [12:0] stack_din;
    logic        irq_ack;
    logic        stack_ovf;
    logic        stack_unf;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .op_kind    (op_kind),
        .target     (target),
        .pclath     (pclath),
        .pcl_wdata  (pcl_wdata),
        .irq        (irq),
        .stack_top  (stack_top),
        .pc         (pc),
        .flush      (flush),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .stack_din  (stack_din),
        .irq_ack    (irq_ack),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] pc;
        logic        flush;
        logic        push;
        logic        pop;
        logic        ack;
        logic [12:0] din;
        logic        ovf;
        logic        unf;
        bit          chk_strobe;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   done    = 1'b0;

    // Reference model: plain integers describing the architectural state
    int m_pc    = 0;
    bit m_flush = 1'b1;
    int m_depth = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle(input bit r, input bit c, input int k, input int t, input int pl,
                         input int w, input bit i, input int st);
        exp_t e;
        int   nk;
        @(negedge clk);
        rst       = r;
        ce        = c;
        op_kind   = 3'(k);
        target    = 11'(t);
        pclath    = 5'(pl);
        pcl_wdata = 8'(w);
        irq       = i;
        stack_top = 13'(st);
        nk = (k > 5) ? 0 : k;

        e.pc    = 13'(m_pc);
        e.flush = m_flush;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.push  = 1'b0;
        e.pop   = 1'b0;
        e.ack   = 1'b0;
        e.din   = 13'(m_pc);
        if (c && !m_flush) begin
            if (nk == 0 && i) begin
                e.push = 1'b1;
                e.ack  = 1'b1;
                e.din  = 13'((m_pc + 1) % 8192);
            end else if (nk == 2) begin
                e.push = 1'b1;
            end else if (nk == 3) begin
                e.pop = 1'b1;
            end
        end
        e.chk_strobe = !r;
        q.push_back(e);

        if (r) begin
            m_pc = 0; m_flush = 1'b1; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (c) begin
            if (m_flush) begin
                m_pc = (m_pc + 1) % 8192;
                m_flush = 1'b0;
            end else begin
                if (e.push) begin
                    if (m_depth == 8) m_ovf = 1'b1;
                    else m_depth++;
                end
                if (e.pop) begin
                    if (m_depth == 0) m_unf = 1'b1;
                    else m_depth--;
                end
                m_flush = 1'b1;
                if (e.ack) m_pc = 4;
                else begin
                    case (nk)
                        1, 2: m_pc = ((pl >> 3) & 3) * 2048 + t;
                        3:    m_pc = st;
                        4:    m_pc = pl * 256 + w;
                        5:    m_pc = (m_pc + 1) % 8192;
                        default: begin
                            m_pc = (m_pc + 1) % 8192;
                            m_flush = 1'b0;
                        end
                    endcase
                end
            end
        end
    endtask

    // Shorthand: running cycle, no reset
    task automatic op(input int k, input int t, input int pl, input int w, input bit i, input int st);
        cycle(1'b0, 1'b1, k, t, pl, w, i, st);
    endtask

    // Monitor: pops one expectation per cycle and compares against the DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("stack_ovf", 32'(stack_ovf), 32'(e.ovf));
                chk("stack_unf", 32'(stack_unf), 32'(e.unf));
                if (e.chk_strobe) begin
                    chk("stack_push", 32'(stack_push), 32'(e.push));
                    chk("stack_pop", 32'(stack_pop), 32'(e.pop));
                    chk("irq_ack", 32'(irq_ack), 32'(e.ack));
                    chk("stack_din", 32'(stack_din), 32'(e.din));
                end
            end else if (done) begin
                break;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        rst = 1'b1; ce = 1'b0; op_kind = 3'd0; target = 11'd0; pclath = 5'd0;
        pcl_wdata = 8'd0; irq = 1'b0; stack_top = 13'd0;
        repeat (2) @(negedge clk);

        cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        repeat (3) op(0, 0, 0, 0, 1'b0, 0);

        op(1, 'h010, 0, 0, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        op(2, 'h123, 'b01000, 0, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        op(3, 0, 0, 0, 1'b0, 'h010);
        op(0, 0, 0, 0, 1'b0, 0);

        op(1, 'h03F, 0, 0, 1'b1, 0);
        op(0, 0, 0, 0, 1'b1, 0);
        op(0, 0, 0, 0, 1'b1, 0);
        op(0, 0, 0, 0, 1'b0, 0);

        for (int n = 0; n < 9; n++) begin
            op(2, 'h100 + n, 0, 0, 1'b0, 0);
            op(0, 0, 0, 0, 1'b0, 0);
        end
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        op(3, 0, 0, 0, 1'b0, 'h055);
        op(0, 0, 0, 0, 1'b0, 0);

        op(4, 0, 'h1F, 'hFE, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        op(0, 0, 0, 0, 1'b0, 0);
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 1'b0, n % 6, 'h7FF, 'h1F, 'hAA, 1'b1, 'h1234);
        end
        // Reset while in the flush slot after a branch with irq pending
        op(1, 'h200, 0, 0, 1'b1, 0);
        cycle(1'b1, 1'b1, 0, 0, 0, 0, 1'b1, 0);
        op(0, 0, 0, 0, 1'b1, 0);
        op(0, 0, 0, 0, 1'b0, 0);

        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 8),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 8191)));
        end
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        done = 1'b1;
    end

endmodule
